// File: rtl/raster_scan_timing.sv
`default_nettype none
// ============================================================================
// raster_scan_timing : raster timing generator and pixel output stage; drives
// the converter's scan inputs and maps returned intensity onto VGA RGB pins.
// Optional build macro RASTER_PHOSPHOR_EN selects P7 two-layer colouring.
// Revision: 1.0
// ============================================================================
module raster_scan_timing #(
  parameter int X_WIDTH     = 10,
  parameter int Y_WIDTH     = 10,
  parameter int AGE_WIDTH   = 8,
  parameter int H_ACTIVE    = 1024,
  parameter int H_FP        = 24,
  parameter int H_SYNC      = 136,
  parameter int H_BP        = 160,
  parameter int V_ACTIVE    = 768,
  parameter int V_FP        = 3,
  parameter int V_SYNC      = 6,
  parameter int V_BP        = 29,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int PIX_LATENCY = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [AGE_WIDTH-1:0] pixel_i,
  output logic [X_WIDTH-1:0]   xout_o,
  output logic [Y_WIDTH-1:0]   yout_o,
  output logic                 newline_o,
  output logic                 newframe_o,
  output logic                 hsync_o,
  output logic                 vsync_o,
  output logic                 de_o,
  output logic [7:0]           r_o,
  output logic [7:0]           g_o,
  output logic [7:0]           b_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HC_W = ($clog2(H_TOTAL + 1) > X_WIDTH) ? $clog2(H_TOTAL + 1) : X_WIDTH;
  localparam int VC_W = ($clog2(V_TOTAL + 1) > Y_WIDTH) ? $clog2(V_TOTAL + 1) : Y_WIDTH;
`ifdef RASTER_PHOSPHOR_EN
  localparam int STAGES = PIX_LATENCY + 2;
`else
  localparam int STAGES = PIX_LATENCY + 1;
`endif

  localparam logic [HC_W-1:0] c_h_last   = HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0] c_h_active = HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0] c_hs_start = HC_W'(H_ACTIVE + H_FP);
  localparam logic [HC_W-1:0] c_hs_end   = HC_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VC_W-1:0] c_v_last   = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0] c_v_active = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0] c_vs_start = VC_W'(V_ACTIVE + V_FP);
  localparam logic [VC_W-1:0] c_vs_end   = VC_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [HC_W-1:0]   r_hcnt;
  logic [VC_W-1:0]   r_vcnt;
  logic [STAGES-1:0] r_act_pipe;
  logic [STAGES-1:0] r_hs_pipe;
  logic [STAGES-1:0] r_vs_pipe;
  logic [23:0]       r_rgb;
  logic              w_h_vis;
  logic              w_v_vis;
  logic              w_active;
  logic              w_hs_raw;
  logic              w_vs_raw;
  logic              w_act_tap;
  logic [7:0]        w_i8;
  logic [7:0]        w_r;
  logic [7:0]        w_g;
  logic [7:0]        w_b;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (r_hcnt == c_h_last) begin
      r_hcnt <= '0;
      r_vcnt <= (r_vcnt == c_v_last) ? '0 : r_vcnt + 1'b1;
    end else begin
      r_hcnt <= r_hcnt + 1'b1;
    end
  end

  assign w_h_vis  = (r_hcnt < c_h_active);
  assign w_v_vis  = (r_vcnt < c_v_active);
  assign w_active = w_h_vis & w_v_vis;
  assign w_hs_raw = (r_hcnt >= c_hs_start) && (r_hcnt < c_hs_end);
  assign w_vs_raw = (r_vcnt >= c_vs_start) && (r_vcnt < c_vs_end);

  assign xout_o     = w_h_vis ? r_hcnt[X_WIDTH-1:0] : '0;
  assign yout_o     = w_v_vis ? r_vcnt[Y_WIDTH-1:0] : '0;
  assign newline_o  = rst_n_i & (r_hcnt == c_h_active);
  assign newframe_o = rst_n_i & (r_hcnt == '0) & (r_vcnt == c_v_active);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_act_pipe <= '0;
      r_hs_pipe  <= '0;
      r_vs_pipe  <= '0;
    end else begin
      r_act_pipe[0] <= w_active;
      r_hs_pipe[0]  <= w_hs_raw;
      r_vs_pipe[0]  <= w_vs_raw;
      for (int s = 1; s < STAGES; s++) begin
        r_act_pipe[s] <= r_act_pipe[s-1];
        r_hs_pipe[s]  <= r_hs_pipe[s-1];
        r_vs_pipe[s]  <= r_vs_pipe[s-1];
      end
    end
  end

  // Active flag as it stood when the pixel now on pixel_i was addressed.
  generate
    if (PIX_LATENCY == 0) begin : g_tap_comb
      assign w_act_tap = w_active;
    end else begin : g_tap_pipe
      assign w_act_tap = r_act_pipe[PIX_LATENCY-1];
    end
  endgenerate

  generate
    if (AGE_WIDTH >= 8) begin : g_i8_top
      assign w_i8 = pixel_i[AGE_WIDTH-1 -: 8];
    end else begin : g_i8_ext
      assign w_i8 = {{(8-AGE_WIDTH){1'b0}}, pixel_i};
    end
  endgenerate

  always_comb begin
    w_r = w_i8;
    w_g = w_i8;
    w_b = w_i8;
`ifdef RASTER_PHOSPHOR_EN
    if (w_i8 >= 8'hE0) begin
      w_r = w_i8 - 8'h20;
      w_g = w_i8 - 8'h10;
      w_b = 8'hFF;
    end else begin
      w_r = {1'b0, w_i8[7:1]};
      w_g = w_i8;
      w_b = {3'b000, w_i8[7:3]};
    end
`endif
  end

`ifdef RASTER_PHOSPHOR_EN
  logic [23:0] r_map;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_map <= '0;
      r_rgb <= '0;
    end else begin
      r_map <= w_act_tap ? {w_r, w_g, w_b} : 24'h0;
      r_rgb <= r_map;
    end
  end
`else
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rgb <= '0;
    end else begin
      r_rgb <= w_act_tap ? {w_r, w_g, w_b} : 24'h0;
    end
  end
`endif

  assign de_o    = r_act_pipe[STAGES-1];
  assign hsync_o = r_hs_pipe[STAGES-1] ? HSYNC_POL : ~HSYNC_POL;
  assign vsync_o = r_vs_pipe[STAGES-1] ? VSYNC_POL : ~VSYNC_POL;
  assign r_o     = r_rgb[23:16];
  assign g_o     = r_rgb[15:8];
  assign b_o     = r_rgb[7:0];

endmodule
`default_nettype wire

// File: tb/tb_raster_scan_timing.sv
`default_nettype none
// ============================================================================
// tb_raster_scan_timing : table vectors plus randomized pixels checked against
// a frame-arithmetic reference model. Revision: 1.0
// ============================================================================
module tb_raster_scan_timing;

  localparam int HA = 8, HFP = 2, HS = 2, HBP = 2;
  localparam int VA = 4, VFP = 1, VS = 1, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int PL = 1;
`ifdef RASTER_PHOSPHOR_EN
  localparam int LAT = PL + 2;
`else
  localparam int LAT = PL + 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pixel_i = 8'h00;
  logic [9:0] xout_o, yout_o;
  logic       newline_o, newframe_o, hsync_o, vsync_o, de_o;
  logic [7:0] r_o, g_o, b_o;

  raster_scan_timing #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .PIX_LATENCY(PL)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .pixel_i(pixel_i),
    .xout_o(xout_o), .yout_o(yout_o), .newline_o(newline_o),
    .newframe_o(newframe_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
    .de_o(de_o), .r_o(r_o), .g_o(g_o), .b_o(b_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pix;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } vec_t;

  vec_t tbl[8];
  int   errors = 0;
  int   checks = 0;
  int   n = 0;
  int   pix_hist[0:4095];
  int   nf_q[$];
  int   vs_low = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, n, act, exp);
    end
  endtask

  function automatic int col_of(input int c);
    return c % HT;
  endfunction

  function automatic int row_of(input int c);
    return (c / HT) % VT;
  endfunction

  function automatic logic [23:0] cmap(input int i);
`ifdef RASTER_PHOSPHOR_EN
    if (i >= 224) return {8'(i - 32), 8'(i - 16), 8'd255};
    else          return {8'(i / 2), 8'(i), 8'(i / 8)};
`else
    return {8'(i), 8'(i), 8'(i)};
`endif
  endfunction

  // mode 0: random, 1: echo of previous xout, 2: constant 0xFF, 3: table values
  task automatic step(input int mode);
    int h, v, k, hk, vk, f, val;
    logic act, ehs, evs;
    logic [23:0] ergb;
    h = col_of(n);
    v = row_of(n);
    chk("xout", int'(xout_o), (h < HA) ? h : 0);
    chk("yout", int'(yout_o), (v < VA) ? v : 0);
    chk("newline", int'(newline_o), int'(h == HA));
    chk("newframe", int'(newframe_o), int'(h == 0 && v == VA));
    k = n - LAT;
    hk = 0;
    if (k < 0) begin
      act = 1'b0; ehs = 1'b1; evs = 1'b1;
    end else begin
      hk  = col_of(k);
      vk  = row_of(k);
      act = (hk < HA) && (vk < VA);
      ehs = !(hk >= HA + HFP && hk < HA + HFP + HS);
      evs = !(vk >= VA + VFP && vk < VA + VFP + VS);
    end
    ergb = act ? cmap(pix_hist[k + PL]) : 24'h0;
    chk("de", int'(de_o), int'(act));
    chk("hsync", int'(hsync_o), int'(ehs));
    chk("vsync", int'(vsync_o), int'(evs));
    chk("r", int'(r_o), int'(ergb[23:16]));
    chk("g", int'(g_o), int'(ergb[15:8]));
    chk("b", int'(b_o), int'(ergb[7:0]));
    if (mode == 3 && act) begin
      chk("tbl_r", int'(r_o), int'(tbl[hk].r));
      chk("tbl_g", int'(g_o), int'(tbl[hk].g));
      chk("tbl_b", int'(b_o), int'(tbl[hk].b));
    end
    if (newframe_o) nf_q.push_back(n);
    if (k >= 0 && k < HT * VT && !vsync_o) vs_low++;

    val = int'($urandom_range(0, 255));
    if (mode == 1) begin
      val = 0;
      if (n >= 1 && col_of(n - 1) < HA) val = col_of(n - 1);
    end else if (mode == 2) begin
      val = 255;
    end else if (mode == 3) begin
      f = n - PL;
      if (f >= 0 && col_of(f) < HA) val = int'(tbl[col_of(f)].pix);
    end
    pix_hist[n] = val;
    pixel_i = 8'(val);
    n++;
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_xout"}, int'(xout_o), 0);
    chk({tag, "_yout"}, int'(yout_o), 0);
    chk({tag, "_newline"}, int'(newline_o), 0);
    chk({tag, "_newframe"}, int'(newframe_o), 0);
    chk({tag, "_de"}, int'(de_o), 0);
    chk({tag, "_hsync"}, int'(hsync_o), 1);
    chk({tag, "_vsync"}, int'(vsync_o), 1);
    chk({tag, "_rgb"}, int'({r_o, g_o, b_o}), 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n = 0;
    nf_q.delete();
    vs_low = 0;
  endtask

  task automatic hard_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    release_reset();
  endtask

  initial begin
`ifdef RASTER_PHOSPHOR_EN
    tbl[0] = '{8'hF0, 8'hD0, 8'hE0, 8'hFF};
    tbl[1] = '{8'h80, 8'h40, 8'h80, 8'h10};
    tbl[2] = '{8'hE0, 8'hC0, 8'hD0, 8'hFF};
    tbl[3] = '{8'hDF, 8'h6F, 8'hDF, 8'h1B};
    tbl[4] = '{8'hFF, 8'hDF, 8'hEF, 8'hFF};
    tbl[5] = '{8'h00, 8'h00, 8'h00, 8'h00};
    tbl[6] = '{8'h01, 8'h00, 8'h01, 8'h00};
    tbl[7] = '{8'h3C, 8'h1E, 8'h3C, 8'h07};
`else
    tbl[0] = '{8'hF0, 8'hF0, 8'hF0, 8'hF0};
    tbl[1] = '{8'h80, 8'h80, 8'h80, 8'h80};
    tbl[2] = '{8'hE0, 8'hE0, 8'hE0, 8'hE0};
    tbl[3] = '{8'hDF, 8'hDF, 8'hDF, 8'hDF};
    tbl[4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    tbl[5] = '{8'h00, 8'h00, 8'h00, 8'h00};
    tbl[6] = '{8'h01, 8'h01, 8'h01, 8'h01};
    tbl[7] = '{8'h3C, 8'h3C, 8'h3C, 8'h3C};
`endif

    repeat (3) @(negedge clk);
    check_reset_values("por");

    // Two frames of echoed column numbers, then saturated and random pixels.
    release_reset();
    for (int c = 0; c < 2 * HT * VT + 4; c++) step(1);
    chk("nf_count", nf_q.size(), 2);
    if (nf_q.size() >= 2) begin
      chk("nf_first", nf_q[0], 4 * HT);
      chk("nf_period", nf_q[1] - nf_q[0], HT * VT);
    end
    chk("vsync_low_cycles", vs_low, HT);
    for (int c = 0; c < 120; c++) step(2);
    for (int c = 0; c < 250; c++) step(0);

    // Reset asserted mid-line at column 5 of row 2.
    hard_reset();
    for (int c = 0; c < 2 * HT + 5; c++) step(0);
    chk("pre_abort_xout", int'(xout_o), 5);
    chk("pre_abort_yout", int'(yout_o), 2);
    rst_n = 1'b0;
    #1;
    check_reset_values("abort");
    @(negedge clk);
    release_reset();
    for (int c = 0; c < HT * VT + 20; c++) step(0);

    // Colour table over every visible row.
    hard_reset();
    for (int c = 0; c < HT * VT; c++) step(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
